// File: rtl/bist_pkg.sv
// Shared types and helpers for the BIST engine: FSM state encoding and the
// generic Fibonacci shift step used by both the pattern LFSR and the MISR.
package bist_pkg;

  localparam int LFSR_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Operands are zero-extended; the caller truncates the result back to its width.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(input logic [LFSR_MAX_W-1:0] state,
                                                      input logic [LFSR_MAX_W-1:0] poly);
    return (state << 1) | LFSR_MAX_W'(^(state & poly));
  endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Loadable Fibonacci shift register; par_in is XORed into the shifted value,
// so the same block serves as pattern generator (par_in=0) and as a MISR.
module bist_lfsr
  import bist_pkg::*;
#(
  parameter int           W    = 4,
  parameter logic [W-1:0] POLY = '0,
  parameter logic [W-1:0] SEED = W'(1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] par_in,
  output logic [W-1:0] value,
  output logic [W-1:0] value_next
);

  logic [W-1:0] r_value;

  if (W < 2 || W > LFSR_MAX_W) begin : g_bad_width
    $error("bist_lfsr: W must be in 2..%0d", LFSR_MAX_W);
  end

  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    value_next = r_value;
    if (load) begin
      value_next = SEED;
    end else if (shift) begin
      value_next = W'(lfsr_step(LFSR_MAX_W'(r_value), LFSR_MAX_W'(POLY))) ^ par_in;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= SEED;
    end else begin
      r_value <= value_next;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/bist_engine.sv
// BIST controller: drives NUM_PAT LFSR patterns into a CUT, compacts the
// responses in a MISR and holds a pass/fail verdict against GOLDEN.
module bist_engine
  import bist_pkg::*;
#(
  parameter int                PAT_W    = 3,
  parameter logic [PAT_W-1:0]  PAT_POLY = 3'b110,
  parameter logic [PAT_W-1:0]  PAT_SEED = 3'b111,
  parameter int                RESP_W   = 1,
  parameter int                SIG_W    = 4,
  parameter logic [SIG_W-1:0]  SIG_POLY = 4'b0100,
  parameter logic [SIG_W-1:0]  SIG_SEED = 4'b0001,
  parameter int                NUM_PAT  = 7,
  parameter int                RESP_LAT = 0,
  parameter logic [SIG_W-1:0]  GOLDEN   = 4'b0100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [PAT_W-1:0]  pattern,
  output logic              pat_valid,
  input  logic [RESP_W-1:0] resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature
);

  localparam int CNT_W = $clog2(NUM_PAT + 1);
  localparam int DRN_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

  if (PAT_SEED == '0) begin : g_bad_seed
    $error("bist_engine: PAT_SEED must be non-zero");
  end
  if (NUM_PAT < 1 || RESP_W > SIG_W || RESP_LAT < 0) begin : g_bad_params
    $error("bist_engine: illegal NUM_PAT, RESP_W or RESP_LAT");
  end

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DRN_W-1:0] r_drain_cnt;
  logic             r_busy, r_done, r_pass, r_pat_valid;

  logic             w_load, w_gen_shift, w_cap, w_misr_shift;
  logic [SIG_W-1:0] w_misr_next, w_resp_ext;
  logic [PAT_W-1:0] w_pat_next;

  assign w_load       = start && !abort && (r_state == IDLE || r_state == DONE);
  assign w_gen_shift  = (r_state == RUN) && !abort;
  assign w_misr_shift = w_cap && !abort;
  assign w_resp_ext   = SIG_W'(resp);

  bist_lfsr #(.W(PAT_W), .POLY(PAT_POLY), .SEED(PAT_SEED)) u_pat_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .shift      (w_gen_shift),
    .par_in     ('0),
    .value      (pattern),
    .value_next (w_pat_next)
  );

  bist_lfsr #(.W(SIG_W), .POLY(SIG_POLY), .SEED(SIG_SEED)) u_misr (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .shift      (w_misr_shift),
    .par_in     (w_resp_ext),
    .value      (signature),
    .value_next (w_misr_next)
  );

  // Capture strobe: pat_valid delayed to line up with the CUT's response latency.
  if (RESP_LAT == 0) begin : g_no_pipe
    assign w_cap = r_pat_valid;
  end else begin : g_pipe
    logic [RESP_LAT-1:0] r_vpipe;
    always_ff @(posedge clk) begin
      if (rst || abort) begin
        r_vpipe <= '0;
      end else begin
        r_vpipe <= RESP_LAT'({r_vpipe, r_pat_valid});
      end
    end
    assign w_cap = r_vpipe[RESP_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_pat_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_pat_valid <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (int'(r_cnt) == NUM_PAT - 1) begin
            r_pat_valid <= 1'b0;
            if (RESP_LAT > 0) begin
              r_state     <= DRAIN;
              r_drain_cnt <= '0;
            end else begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_misr_next == GOLDEN);
            end
          end
        end
        DRAIN: begin
          r_drain_cnt <= r_drain_cnt + DRN_W'(1);
          if (int'(r_drain_cnt) == RESP_LAT - 1) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_misr_next == GOLDEN);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign pat_valid = r_pat_valid;

endmodule

// File: tb/tb_bist_engine.sv
// Directed bench for bist_engine: default build, a NUM_PAT=1 build and a
// RESP_LAT=2 build with a twice-registered parity CUT, sharing control inputs.
module tb_bist_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1, start = 1'b0, abort = 1'b0, stuck = 1'b0;
  logic [2:0] pat0, pat1, pat2;
  logic       pv0, pv1, pv2, busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
  logic [3:0] sig0, sig1, sig2;
  logic       resp0, resp1, resp2, r_cut_a, r_cut_b;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  assign resp0 = stuck ? 1'b0 : ^pat0;
  assign resp1 = ^pat1;
  always @(posedge clk) begin
    r_cut_a <= ^pat2;
    r_cut_b <= r_cut_a;
  end
  assign resp2 = r_cut_b;

  bist_engine dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern(pat0), .pat_valid(pv0),
    .resp(resp0), .busy(busy0), .done(done0), .pass(pass0), .signature(sig0)
  );

  bist_engine #(.NUM_PAT(1), .GOLDEN(4'b0011)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern(pat1), .pat_valid(pv1),
    .resp(resp1), .busy(busy1), .done(done1), .pass(pass1), .signature(sig1)
  );

  bist_engine #(.RESP_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern(pat2), .pat_valid(pv2),
    .resp(resp2), .busy(busy2), .done(done2), .pass(pass2), .signature(sig2)
  );

  typedef struct {
    logic       start;
    logic       abort;
    logic [2:0] pat;
    logic       pv;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] sig;
  } vec_t;

  vec_t       vecs[11];
  logic [2:0] exp_pat[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Pulse start, then count busy cycles of every instance until all report done.
  task automatic run_until_done(output int b0, output int b1, output int b2, output logic ok);
    b0 = 0; b1 = 0; b2 = 0; ok = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busy0) b0++;
      if (busy1) b1++;
      if (busy2) b2++;
      if (done0 && done1 && done2) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  initial begin
    int   b0, b1, b2;
    logic ok;

    exp_pat = '{3'b111, 3'b110, 3'b100, 3'b001, 3'b010, 3'b101, 3'b011};
    //            start abort pat     pv busy done pass sig
    vecs[0]  = '{1'b1, 1'b0, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001};
    vecs[1]  = '{1'b0, 1'b0, 3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0011};
    vecs[2]  = '{1'b0, 1'b0, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0110};
    vecs[3]  = '{1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1100};
    vecs[4]  = '{1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1000};
    vecs[5]  = '{1'b0, 1'b0, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001};
    vecs[6]  = '{1'b0, 1'b0, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0010};
    vecs[7]  = '{1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0100};
    vecs[8]  = '{1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0100};
    vecs[9]  = '{1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100};
    vecs[10] = '{1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100};

    // Reset state
    do_reset();
    check("reset.pattern", pat0, 3'b111);
    check("reset.pat_valid", pv0, 1'b0);
    check("reset.busy", busy0, 1'b0);
    check("reset.done", done0, 1'b0);
    check("reset.pass", pass0, 1'b0);
    check("reset.signature", sig0, 4'b0001);

    // Full default run with a parity CUT, then hold in DONE and abort from DONE
    for (int i = 0; i < 11; i++) begin
      start = vecs[i].start;
      abort = vecs[i].abort;
      step();
      check($sformatf("vec%0d.pattern", i), pat0, vecs[i].pat);
      check($sformatf("vec%0d.pat_valid", i), pv0, vecs[i].pv);
      check($sformatf("vec%0d.busy", i), busy0, vecs[i].busy);
      check($sformatf("vec%0d.done", i), done0, vecs[i].done);
      check($sformatf("vec%0d.pass", i), pass0, vecs[i].pass);
      check($sformatf("vec%0d.signature", i), sig0, vecs[i].sig);
    end
    abort = 1'b0;

    // Response stuck at 0
    do_reset();
    stuck = 1'b1;
    run_until_done(b0, b1, b2, ok);
    check("stuck.timeout", ok, 1'b1);
    check("stuck.signature", sig0, 4'b0010);
    check("stuck.pass", pass0, 1'b0);
    check("stuck.done", done0, 1'b1);
    stuck = 1'b0;

    // Abort on the third RUN cycle, then a clean rerun
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("abort.pattern_before", pat0, 3'b100);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort.busy", busy0, 1'b0);
    check("abort.done", done0, 1'b0);
    check("abort.pat_valid", pv0, 1'b0);
    check("abort.signature_held", sig0, 4'b0110);
    check("abort.lat2_busy", busy2, 1'b0);
    run_until_done(b0, b1, b2, ok);
    check("rerun.timeout", ok, 1'b1);
    check("rerun.signature", sig0, 4'b0100);
    check("rerun.pass", pass0, 1'b1);

    // Busy lengths: default, NUM_PAT=1 and RESP_LAT=2 builds
    do_reset();
    run_until_done(b0, b1, b2, ok);
    check("lat.timeout", ok, 1'b1);
    check("lat0.busy_cycles", b0, 7);
    check("np1.busy_cycles", b1, 1);
    check("np1.signature", sig1, 4'b0011);
    check("np1.pass", pass1, 1'b1);
    check("lat2.busy_cycles", b2, 9);
    check("lat2.signature", sig2, 4'b0100);
    check("lat2.pass", pass2, 1'b1);

    // start held high: no restart while busy, restart right after done
    do_reset();
    start = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      check($sformatf("held%0d.pattern", k), pat0, exp_pat[k]);
      check($sformatf("held%0d.busy", k), busy0, 1'b1);
    end
    step();
    check("held.done", done0, 1'b1);
    check("held.busy_at_done", busy0, 1'b0);
    check("held.pass", pass0, 1'b1);
    step();
    check("held.restart_busy", busy0, 1'b1);
    check("held.restart_done", done0, 1'b0);
    check("held.restart_pattern", pat0, 3'b111);
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;

    // rst mid-run, together with start and abort
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst   = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    step();
    check("rst_mid.busy", busy0, 1'b0);
    check("rst_mid.done", done0, 1'b0);
    check("rst_mid.pass", pass0, 1'b0);
    check("rst_mid.pat_valid", pv0, 1'b0);
    check("rst_mid.pattern", pat0, 3'b111);
    check("rst_mid.signature", sig0, 4'b0001);
    check("rst_mid.lat2_busy", busy2, 1'b0);
    check("rst_mid.lat2_pattern", pat2, 3'b111);
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
